// File: rtl/fifo_burst_reader.sv
// Drain stage behind a show-ahead FIFO: pops words and frames them into
// SOP/EOP bursts of up to burst_len words, closing short bursts after an idle timeout.
module fifo_burst_reader #(
    parameter int width     = 8,
    parameter int burst_len = 16,
    parameter int lenw      = 5,
    parameter int timeout   = 64,
    parameter int tow       = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] FIFO_Q,
    input  logic             FIFO_EMPTY,
    output logic             FIFO_RD,
    output logic [width-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_SOP,
    output logic             OUT_EOP
);

    localparam logic [lenw-1:0] last_pos = lenw'(burst_len);
    localparam logic [lenw-1:0] first_pos = lenw'(1);
    localparam logic [tow-1:0]  icnt_max = tow'(timeout);

    // Pending slot: the word just popped, held until its burst role is known.
    logic             pv;
    logic [width-1:0] p_data;
    logic [lenw-1:0]  ppos;
    logic [lenw-1:0]  pos;
    logic [tow-1:0]   icnt;

    logic            o_free;
    logic            at_end;
    logic            timed_out;
    logic            mv;
    logic            mv_eop;
    logic            pop;
    logic [lenw-1:0] pos_base;
    logic [lenw-1:0] pop_pos;

    always_comb begin
        o_free    = ~OUT_VALID | OUT_READY;
        at_end    = (ppos == last_pos);
        timed_out = (icnt == icnt_max);
        mv        = pv & o_free & (~FIFO_EMPTY | at_end | timed_out);
        mv_eop    = at_end | timed_out;
        pop       = ~RST & ~FIFO_EMPTY & (~pv | mv);
        // A timeout close restarts numbering for a word popped in the same cycle.
        pos_base  = (mv & timed_out) ? '0 : pos;
        pop_pos   = pos_base + first_pos;
    end

    assign FIFO_RD = pop;

    // NOTE: every register here, including the data words, is reset so a
    // mid-burst RST leaves no stale word that could later be emitted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pv        <= 1'b0;
            p_data    <= '0;
            ppos      <= '0;
            pos       <= '0;
            icnt      <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SOP   <= 1'b0;
            OUT_EOP   <= 1'b0;
        end else begin
            if (pop) begin
                pv     <= 1'b1;
                p_data <= FIFO_Q;
                ppos   <= pop_pos;
                pos    <= (pop_pos == last_pos) ? '0 : pop_pos;
            end else begin
                if (mv)
                    pv <= 1'b0;
                if (mv && timed_out)
                    pos <= '0;
            end

            if (pop || mv)
                icnt <= '0;
            else if (pv && FIFO_EMPTY && !timed_out)
                icnt <= icnt + tow'(1);

            if (mv) begin
                OUT_VALID <= 1'b1;
                OUT_DATA  <= p_data;
                OUT_SOP   <= (ppos == first_pos);
                OUT_EOP   <= mv_eop;
            end else if (o_free) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: behavioural FIFO plus a word/burst scoreboard that
// predicts SOP/EOP from burst counts and the idle gaps the bench itself creates.
module tb_fifo_burst_reader;

    localparam int BL = 16;
    localparam int TO = 64;
    localparam int LONG_GAP = 150;

    typedef struct packed {
        logic [7:0] data;
        logic       long_gap;   // followed by an idle gap well beyond the timeout
    } word_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] FIFO_Q = '0;
    logic       FIFO_EMPTY = 1'b1;
    logic       FIFO_RD;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic       OUT_SOP;
    logic       OUT_EOP;

    always #5 CLK = ~CLK;

    fifo_burst_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .FIFO_Q    (FIFO_Q),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RD   (FIFO_RD),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_SOP   (OUT_SOP),
        .OUT_EOP   (OUT_EOP)
    );

    word_t fifo[$];
    word_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int burst_cnt = 0;
    int rd_count = 0;
    int acc_count = 0;
    int first_acc = -1;
    int last_acc = 0;
    int last_pop = 0;
    int last_appear = 0;
    int ready_mode = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] held = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        FIFO_EMPTY = (fifo.size() == 0);
        FIFO_Q     = (fifo.size() == 0) ? 8'h00 : fifo[0].data;
    endtask

    task automatic push(input logic [7:0] d, input logic lg);
        word_t w;
        w.data = d;
        w.long_gap = lg;
        fifo.push_back(w);
        exp_q.push_back(w);
        drive_fifo();
    endtask

    task automatic reset_stats();
        rd_count  = 0;
        acc_count = 0;
        first_acc = -1;
        last_acc  = 0;
    endtask

    // One clock: observe at the falling edge, update FIFO and READY just after the rising edge.
    task automatic cycle();
        word_t      e;
        logic [9:0] now;
        logic       rd;
        logic       exp_eop;
        @(negedge CLK);
        now = {OUT_DATA, OUT_SOP, OUT_EOP};
        rd  = FIFO_RD;
        if (!RST) begin
            if (prev_stall)
                check("stall_hold", {OUT_VALID, now}, {1'b1, held});
            if (OUT_VALID && !prev_stall)
                last_appear = cyc;
            if (rd) begin
                check("rd_when_empty", FIFO_EMPTY, 0);
                rd_count++;
                last_pop = cyc + 1;
            end
            if (OUT_VALID && OUT_READY) begin
                acc_count++;
                if (first_acc < 0)
                    first_acc = cyc;
                last_acc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    burst_cnt++;
                    exp_eop = (burst_cnt == BL) || e.long_gap;
                    check("word", now, {e.data, burst_cnt == 1, exp_eop});
                    if (exp_eop)
                        burst_cnt = 0;
                end
            end
            prev_stall = OUT_VALID & ~OUT_READY;
            held = now;
        end else begin
            check("rst_rd", rd, 0);
            prev_stall = 1'b0;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rd && !RST && fifo.size() != 0)
            void'(fifo.pop_front());
        drive_fifo();
        case (ready_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: OUT_READY = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_fifo_empty(input int budget);
        int n = 0;
        while (fifo.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("fifo_empty_timeout", fifo.size(), 0);
    endtask

    initial begin
        int n;
        int remaining;
        logic lg;

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_out", {FIFO_RD, OUT_VALID, OUT_SOP, OUT_EOP, OUT_DATA}, 0);
        RST = 1'b0;
        OUT_READY = 1'b1;
        ready_mode = 0;

        // Full burst of 16 preloaded words, back to back.
        reset_stats();
        for (int i = 0; i < 16; i++)
            push(8'(i), 1'b0);
        drain("t1_drain", 200);
        check("t1_count", acc_count, 16);
        check("t1_span", last_acc - first_acc, 15);
        check("t1_rd_pulses", rd_count, 16);

        // 37 words: bursts 16,16,5 with the last closed by timeout.
        reset_stats();
        for (int i = 0; i < 37; i++)
            push(8'(i), i == 36);
        drain("t2_drain", 400);
        check("t2_count", acc_count, 37);
        check("t2_tail_latency", last_appear - last_pop, TO + 1);

        // Lone word: emitted as a one-word burst after the timeout.
        reset_stats();
        push(8'hA5, 1'b1);
        drain("t3_drain", 200);
        check("t3_count", acc_count, 1);
        check("t3_latency", last_appear - last_pop, TO + 1);

        // Back-pressure pattern 1,0,0,1.
        reset_stats();
        ready_mode = 1;
        for (int i = 0; i < 16; i++)
            push(8'(i), 1'b0);
        drain("t4_drain", 300);
        check("t4_count", acc_count, 16);
        ready_mode = 0;
        OUT_READY = 1'b1;

        // Refill before the timeout: burst continues.
        reset_stats();
        push(8'h33, 1'b0);
        n = 0;
        while (rd_count == 0 && n < 20) begin
            cycle();
            n++;
        end
        check("t5_pop_seen", rd_count, 1);
        repeat (40) cycle();
        push(8'h34, 1'b1);
        drain("t5_drain", 200);
        check("t5_count", acc_count, 2);
        check("t5_latency", last_appear - last_pop, TO + 1);

        // Reset in the middle of a burst.
        reset_stats();
        for (int i = 0; i < 16; i++)
            push(8'(8'h40 + i), i == 15);
        n = 0;
        while (acc_count < 7 && n < 100) begin
            cycle();
            n++;
        end
        check("t6_reached7", acc_count, 7);
        RST = 1'b1;
        #1;
        check("t6_rst_out", {FIFO_RD, OUT_VALID, OUT_SOP, OUT_EOP, OUT_DATA}, 0);
        exp_q = fifo;
        remaining = fifo.size();
        burst_cnt = 0;
        repeat (3) cycle();
        RST = 1'b0;
        drain("t6_drain", 400);
        check("t6_resumed", acc_count - 7, remaining);

        // Randomized batches, random back-pressure, short and long idle gaps.
        ready_mode = 2;
        for (int b = 0; b < 12; b++) begin
            n  = $urandom_range(1, 40);
            lg = (b == 11) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++)
                push(8'($urandom), lg && (i == n - 1));
            wait_fifo_empty(2000);
            if (lg)
                repeat (LONG_GAP) cycle();
            else
                repeat ($urandom_range(0, 10)) cycle();
        end
        drain("rand_drain", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Drain stage directly downstream of the team's synchronous show-ahead FIFO (read data valid whenever not empty; read strobe advances the pointer on the next edge).
- Pops words from the FIFO and presents them on a valid/ready stream, framed into bursts of up to burst_len words with SOP/EOP markers.
- Closes a short burst early when the FIFO stays empty for timeout cycles; feeds the DMA request/packet builder.

Parameters:
- width, 8, data word width (matches FIFO width).
- burst_len, 16, maximum words per burst; legal range 1..2^lenw-1.
- lenw, 5, width of position counter.
- timeout, 64, idle cycles before a partial burst is closed; legal range 1..2^tow-1.
- tow, 7, width of idle counter.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- FIFO_Q  in  width  FIFO head word, valid when FIFO_EMPTY=0.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_RD  out  1  FIFO pop strobe.
- OUT_DATA  out  width  stream data.
- OUT_VALID  out  1  stream word valid.
- OUT_READY  in  1  downstream accept.
- OUT_SOP  out  1  first word of burst (qualified by OUT_VALID).
- OUT_EOP  out  1  last word of burst (qualified by OUT_VALID).

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-high.
- Reset: FIFO_RD=0, OUT_VALID=0, OUT_SOP=0, OUT_EOP=0, OUT_DATA=0. Pending slot empty, POS=0, ICNT=0. RST mid-operation discards pending and output words without handshake. No FIFO pop while RST=1.
- Two stages:
  - Pending register P: PV flag, data, position PPOS.
  - Output register O: drives OUT_*.
- Handshake: a word transfers when OUT_VALID & OUT_READY. While OUT_VALID=1 and OUT_READY=0, OUT_DATA/SOP/EOP are held stable.
- O free = (OUT_VALID=0) or (OUT_VALID & OUT_READY).
- Move P->O (MV) when PV=1, O free, and any of the following holds:
  - (a) FIFO_EMPTY=0: a successor exists, EOP=0 unless (b) applies.
  - (b) PPOS==burst_len: EOP=1.
  - (c) ICNT==timeout: EOP=1.
- On MV, SOP=(PPOS==1).
- FIFO_RD = ~FIFO_EMPTY & (~PV | MV). FIFO_RD is combinational from registered state and inputs; it is never asserted while FIFO_EMPTY=1.
- On pop: P<=FIFO_Q, PV<=1, PPOS<=POS+1. POS holds the position of the last popped word; POS<=0 once a word with PPOS==burst_len is popped, or when a timeout EOP is moved out.
- If MV without pop, PV<=0.
- If O free and no MV, OUT_VALID<=0.
- ICNT: increments (saturating at timeout) each cycle PV=1, FIFO_EMPTY=1 and no MV. Cleared on any pop or MV.
- Latency: a word popped on edge n reaches OUT_VALID at earliest after edge n+1, given a successor or burst end. A lone trailing word appears after timeout+1 further cycles.
- Throughput: one word/cycle sustained with OUT_READY=1 and FIFO non-empty.
- Simultaneous events:
  - Pop and MV in the same cycle are legal; P is reloaded.
  - Burst end via (b) takes precedence over (a); EOP=1 even if the FIFO is non-empty.
- Width: POS/PPOS are lenw bits and never exceed burst_len. ICNT is tow bits.
- Words are never dropped, duplicated or reordered outside reset.

Test Plan:
- FIFO preloaded with 16 words 0x00..0x0F, OUT_READY=1 -> 16 consecutive OUT_VALID cycles, data 0x00..0x0F, SOP on 0x00, EOP on 0x0F; exactly 16 FIFO_RD pulses.
- 37 words 0x00..0x24 preloaded -> bursts of 16, 16, 5. The last word 0x24 is emitted with EOP=1 after 64 idle cycles; SOP on 0x00, 0x10, 0x20.
- Single word 0xA5 into empty FIFO -> OUT_VALID rises 65 cycles after the pop, data 0xA5, SOP=1 and EOP=1 together.
- 16 words with OUT_READY toggled 1,0,0,1 repeating -> OUT_DATA/SOP/EOP stable while stalled. Sequence 0x00..0x0F intact; FIFO_RD never asserted when FIFO_EMPTY=1 or P held.
- Word 0x33 pending, FIFO refilled with 0x34 at idle cycle 40 -> 0x33 emitted with EOP=0, ICNT cleared, burst continues with 0x34 at position 2.
- Assert RST after 7 of 16 words delivered -> all outputs 0 immediately. After release, the next popped word is emitted with SOP=1 at position 1.
